cronometro_progressivo: RTL

- Cascaded BCD up-counting MM:SS stopwatch.
- It is the counting-up counterpart of the team's preset-loaded countdown timer, which is built from the decade, mod-6 and mod-3 decrementers.
- It advances on a 1 Hz enable pulse, is controlled by a start/stop/clear FSM, and flags when the count reaches a programmable BCD target or the maximum value.
- It sits beside the countdown timer in the clock/timer datapath and feeds the same display decoders.

---
 rtl/cronometro_progressivo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cronometro_progressivo.sv
// Cascaded BCD MM:SS up-counting stopwatch.
// Counts on a one-clock 1 Hz enable while running, with start/stop/clear control,
// a programmable BCD target and a configurable behaviour at MINUTE_MAX:59.
module cronometro_progressivo #(
   parameter int MINUTE_MAX  = 59,    // highest minute value, 1..99
   parameter bit HOLD_AT_MAX = 1'b1   // 1: saturate and stop, 0: wrap and keep running
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic [7:0] alvo_min,
   input  logic [7:0] alvo_seg,
   output logic [7:0] minutos,
   output logic [7:0] segundos,
   output logic       rodando,
   output logic       alvo_atingido,
   output logic       estouro
);

   // BCD digits of the top minute value
   localparam logic [3:0] MAX_MT = 4'(MINUTE_MAX / 10);
   localparam logic [3:0] MAX_MU = 4'(MINUTE_MAX % 10);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state_q;
   logic [3:0] su_q, st_q, mu_q, mt_q;      // seconds units/tens, minute units/tens
   logic       rodando_q, alvo_q, estouro_q;

   // next-state digits for one counting step
   logic [3:0] su_d, st_d, mu_d, mt_d;
   logic       at_max;
   logic       tgt_ok;
   logic       tgt_hit;

   assign minutos       = {mt_q, mu_q};
   assign segundos      = {st_q, su_q};
   assign rodando       = rodando_q;
   assign alvo_atingido = alvo_q;
   assign estouro       = estouro_q;

   // Digit chain increment with carries, plus the MINUTE_MAX:59 override
   always_comb begin
      logic c_su, c_st, c_mu;
      c_su = (su_q == 4'd9);
      c_st = c_su && (st_q == 4'd5);
      c_mu = c_st && (mu_q == 4'd9);

      su_d = c_su ? 4'd0 : su_q + 4'd1;
      st_d = st_q;
      if (c_su) st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
      mu_d = mu_q;
      if (c_st) mu_d = (mu_q == 4'd9) ? 4'd0 : mu_q + 4'd1;
      mt_d = mt_q;
      if (c_mu) mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;

      at_max = (mt_q == MAX_MT) && (mu_q == MAX_MU) && (st_q == 4'd5) && (su_q == 4'd9);
      if (at_max) begin
         // saturation keeps the current (maximum) value, wrap goes to 00:00
         if (HOLD_AT_MAX) begin
            su_d = su_q;
            st_d = st_q;
            mu_d = mu_q;
            mt_d = mt_q;
         end else begin
            su_d = 4'd0;
            st_d = 4'd0;
            mu_d = 4'd0;
            mt_d = 4'd0;
         end
      end
   end

   // Target is usable only when all digits are valid BCD, within range and non-zero.
   // With valid digits the BCD byte compares correctly as an unsigned number.
   always_comb begin
      tgt_ok = (alvo_min[3:0] <= 4'd9) && (alvo_min[7:4] <= 4'd9) &&
               (alvo_seg[3:0] <= 4'd9) && (alvo_seg[7:4] <= 4'd5) &&
               (alvo_min <= {MAX_MT, MAX_MU}) &&
               ((alvo_min | alvo_seg) != 8'h00);
      // compared against the post-increment value, so only a landing step matches
      tgt_hit = tgt_ok && ({mt_d, mu_d, st_d, su_d} == {alvo_min, alvo_seg});
   end

   // Control FSM, count registers and registered flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         su_q      <= 4'd0;
         st_q      <= 4'd0;
         mu_q      <= 4'd0;
         mt_q      <= 4'd0;
         rodando_q <= 1'b0;
         alvo_q    <= 1'b0;
         estouro_q <= 1'b0;
      end else begin
         // in wrap mode the overflow flag is a single-cycle pulse
         if (!HOLD_AT_MAX) estouro_q <= 1'b0;

         if (clear) begin
            state_q   <= S_IDLE;
            su_q      <= 4'd0;
            st_q      <= 4'd0;
            mu_q      <= 4'd0;
            mt_q      <= 4'd0;
            rodando_q <= 1'b0;
            alvo_q    <= 1'b0;
            estouro_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_PAUSE: begin
                  // stop outranks start; the tick on the start edge is not counted
                  if (!stop && start) begin
                     state_q   <= S_RUN;
                     rodando_q <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (stop) begin
                     state_q   <= S_PAUSE;
                     rodando_q <= 1'b0;
                  end else if (tick) begin
                     if (tgt_hit) begin
                        // target wins even when the maximum is hit on the same tick
                        su_q      <= su_d;
                        st_q      <= st_d;
                        mu_q      <= mu_d;
                        mt_q      <= mt_d;
                        state_q   <= S_DONE;
                        rodando_q <= 1'b0;
                        alvo_q    <= 1'b1;
                     end else if (at_max && HOLD_AT_MAX) begin
                        state_q   <= S_DONE;
                        rodando_q <= 1'b0;
                        estouro_q <= 1'b1;
                     end else begin
                        su_q <= su_d;
                        st_q <= st_d;
                        mu_q <= mu_d;
                        mt_q <= mt_d;
                        if (at_max) estouro_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  // DONE: held until clear or reset
               end
            endcase
         end
      end
   end

endmodule
